bin_ex3: RTL and testbench
==========================

# bin_ex3

Registered 4-bit binary/BCD to excess-3 code converter with a companion excess-3 to binary decoder path. One input nibble `a` is converted in parallel two ways: `y1` is the excess-3 encoding of `a`, and `y2` treats `a` as an excess-3 code and recovers its binary value. Code-validity flags accompany each result. The block sits as a leaf in a code-conversion datapath and feeds downstream display or BCD-arithmetic logic.

## Interface
- No parameters; all widths fixed at 4 bits.
- `clk` in 1: single clock, all state updates on its rising edge.
- `rst` in 1: synchronous reset, active-high, sampled on the rising edge of `clk`.
- `a` in 4: input nibble, sampled every cycle with no handshake.
- `y1` out 4: excess-3 code of `a`, equal to `a + 3` modulo 16, registered.
- `y2` out 4: binary value of `a` read as excess-3, equal to `a - 3` modulo 16, registered.
- `err1` out 1: registered; 1 when `a` is not a valid BCD digit (`a > 9`), so `y1` is not a legal excess-3 code.
- `err2` out 1: registered; 1 when `a` is not a legal excess-3 code (`a < 3` or `a > 12`).

## Operation
- Each rising edge with `rst=0` loads all four outputs from the current `a`:
  - `y1 <= a + 4'd3`, truncated to 4 bits. Carry-out is discarded, so 13→0, 14→1 and 15→2.
  - `y2 <= a + 4'd13`, which is the two's-complement form of `a - 3`, truncated to 4 bits. So 0→13, 1→14 and 2→15.
  - `err1 <= (a >= 10)`.
  - `err2 <= (a <= 2) || (a >= 13)`.
- Outputs are always driven, including for invalid codes. The flags only qualify the results; they never alter them.
- Arithmetic is implemented as a 4-bit ripple-carry adder built from full-adder cells, one instance per path. The constant operand is tied off (0011 for `y1`, 1101 for `y2`). Behavioural `+` is an acceptable equivalent if results match bit-for-bit.
- The block has no state machine and no memory beyond the output registers.
- The `y1` and `y2` paths are inverse over the legal ranges:
  - For `a` in 0..9, feeding `y1` back into `a` produces the original value on `y2` one cycle later.
  - The same round-trip identity holds modulo 16 for all 16 values.

## Timing
- Latency is one clock: a value applied to `a` before edge N appears on `y1`, `y2`, `err1` and `err2` after edge N.
- Throughput is one conversion per cycle. `a` may change every cycle.
- Reset values: `y1=0000`, `y2=0000`, `err1=0`, `err2=0`.
  - Reset takes effect only on a rising edge with `rst=1`.
  - Reset has priority over loading `a`.
- Asserting `rst` mid-stream clears the outputs on that edge. The first conversion after deassertion appears on the first edge with `rst=0`.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold `rst=1` for 2 edges with `a=7` -> `y1=0`, `y2=0`, `err1=0`, `err2=0`. Release with `a=7` -> next edge gives `y1=10`, `y2=4`, `err1=0`, `err2=0`.
- Full sweep: drive `a` = 0..15, one value per cycle (the counter from 0 wrapping back to 0), and check each output one edge later:
  - `a=0` -> `y1=3`, `y2=13`, `err2=1`.
  - `a=9` -> `y1=12`, `y2=6`, both flags 0.
  - `a=15` -> `y1=2`, `y2=12`, `err1=1`, `err2=1`.
- Wrap boundaries:
  - `a=12` -> `y1=15`, `err1=1`, `err2=0`.
  - `a=13` -> `y1=0`, `y2=10`, `err2=1`.
  - `a=3` -> `y2=0`, `err2=0`.
  - `a=2` -> `y2=15`, `err2=1`.
- Round trip: apply `a=5` (gives `y1=8`), then apply `a=8` -> `y2=5`. Repeat for all BCD digits 0..9.
- Mid-stream reset: while sweeping, assert `rst` for one edge at `a=6` -> outputs 0 on that edge. On the next edge with `a=7` -> `y1=10`, `y2=4`.
- Back-to-back change: alternate `a` between 0 and 15 every cycle -> `y1` alternates 3/2 and `y2` alternates 13/12, each with exactly one-cycle latency.

Source files
------------

// File: rtl/bin_ex3.sv
// Registered 4-bit excess-3 encoder (a+3) and decoder (a-3) with code-validity flags.
// Each path is a 4-bit ripple-carry adder against a tied-off constant operand.

module bin_ex3_fa (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);
  always_comb begin
    s    = x ^ y ^ cin;
    cout = (x & y) | (cin & (x ^ y));
  end
endmodule

module bin_ex3_rca4 (
  input  logic [3:0] x,
  input  logic [3:0] k,
  output logic [3:0] s
);
  logic [3:0] c;

  assign c[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < 3; i++) begin : g_fa
      bin_ex3_fa u_fa (
        .x    (x[i]),
        .y    (k[i]),
        .cin  (c[i]),
        .s    (s[i]),
        .cout (c[i+1])
      );
    end
  endgenerate

  // Carry-out of the MSB is discarded (mod-16 result), so only its sum is formed.
  assign s[3] = x[3] ^ k[3] ^ c[3];
endmodule

module bin_ex3 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  output logic [3:0] y1,
  output logic [3:0] y2,
  output logic       err1,
  output logic       err2
);
  localparam logic [3:0] K_ENC = 4'b0011;
  localparam logic [3:0] K_DEC = 4'b1101;

  logic [3:0] sum_enc;
  logic [3:0] sum_dec;
  logic [3:0] y1_d, y1_q;
  logic [3:0] y2_d, y2_q;
  logic       err1_d, err1_q;
  logic       err2_d, err2_q;

  bin_ex3_rca4 u_enc (
    .x (a),
    .k (K_ENC),
    .s (sum_enc)
  );

  bin_ex3_rca4 u_dec (
    .x (a),
    .k (K_DEC),
    .s (sum_dec)
  );

  always_comb begin
    y1_d   = sum_enc;
    y2_d   = sum_dec;
    err1_d = (a >= 4'd10);
    err2_d = (a <= 4'd2) || (a >= 4'd13);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y1_q   <= 4'd0;
      y2_q   <= 4'd0;
      err1_q <= 1'b0;
      err2_q <= 1'b0;
    end else begin
      y1_q   <= y1_d;
      y2_q   <= y2_d;
      err1_q <= err1_d;
      err2_q <= err2_d;
    end
  end

  assign y1   = y1_q;
  assign y2   = y2_q;
  assign err1 = err1_q;
  assign err2 = err2_q;
endmodule

// File: tb/tb_bin_ex3.sv
// Directed self-checking bench for bin_ex3 using hand-computed code tables.

module tb_bin_ex3;
  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] y1;
  logic [3:0] y2;
  logic       err1;
  logic       err2;

  int n_cmp;
  int n_fail;

  // Hand-computed expected outputs indexed by input nibble.
  logic [3:0] t_y1 [16] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10,
                            4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
  logic [3:0] t_y2 [16] = '{4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                            4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
  logic       t_e1 [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic       t_e2 [16] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  bin_ex3 dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .y1   (y1),
    .y2   (y2),
    .err1 (err1),
    .err2 (err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [3:0] av, input logic rv);
    a   = av;
    rst = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ey1, input logic [3:0] ey2,
                         input logic ee1, input logic ee2);
    chk({tag, ".y1"}, y1, ey1);
    chk({tag, ".y2"}, y2, ey2);
    chk({tag, ".err1"}, 4'(err1), 4'(ee1));
    chk({tag, ".err2"}, 4'(err2), 4'(ee2));
  endtask

  initial begin
    logic [3:0] fb;
    n_cmp  = 0;
    n_fail = 0;
    a      = 4'd7;
    rst    = 1'b1;

    // Reset held for two edges with a=7.
    step(4'd7, 1'b1);
    chk_all("rst_edge1", 4'd0, 4'd0, 1'b0, 1'b0);
    step(4'd7, 1'b1);
    chk_all("rst_edge2", 4'd0, 4'd0, 1'b0, 1'b0);
    step(4'd7, 1'b0);
    chk_all("rst_release_a7", 4'd10, 4'd4, 1'b0, 1'b0);

    // Full sweep 0..15, then wrap to 0.
    for (int i = 0; i < 17; i++) begin
      step(4'(i), 1'b0);
      chk_all($sformatf("sweep_a%0d", i % 16), t_y1[i % 16], t_y2[i % 16],
              t_e1[i % 16], t_e2[i % 16]);
    end

    // Explicit wrap boundaries.
    step(4'd12, 1'b0);
    chk_all("wrap_a12", 4'd15, 4'd9, 1'b1, 1'b0);
    step(4'd13, 1'b0);
    chk_all("wrap_a13", 4'd0, 4'd10, 1'b1, 1'b1);
    step(4'd3, 1'b0);
    chk_all("wrap_a3", 4'd6, 4'd0, 1'b0, 1'b0);
    step(4'd2, 1'b0);
    chk_all("wrap_a2", 4'd5, 4'd15, 1'b0, 1'b1);

    // Round trip: encode d, feed y1 back, decoder must return d.
    for (int d = 0; d < 16; d++) begin
      step(4'(d), 1'b0);
      chk($sformatf("rt_enc_d%0d", d), y1, t_y1[d]);
      fb = y1;
      step(fb, 1'b0);
      chk($sformatf("rt_dec_d%0d", d), y2, 4'(d));
    end

    // Mid-stream reset at a=6.
    step(4'd4, 1'b0);
    chk_all("mid_a4", 4'd7, 4'd1, 1'b0, 1'b0);
    step(4'd5, 1'b0);
    chk_all("mid_a5", 4'd8, 4'd2, 1'b0, 1'b0);
    step(4'd6, 1'b1);
    chk_all("mid_rst_a6", 4'd0, 4'd0, 1'b0, 1'b0);
    step(4'd7, 1'b0);
    chk_all("mid_after_a7", 4'd10, 4'd4, 1'b0, 1'b0);

    // Back-to-back alternation 0/15.
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        step(4'd0, 1'b0);
        chk_all($sformatf("alt%0d_a0", k), 4'd3, 4'd13, 1'b0, 1'b1);
      end else begin
        step(4'd15, 1'b0);
        chk_all($sformatf("alt%0d_a15", k), 4'd2, 4'd12, 1'b1, 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
